test_crc_seq: RTL and testbench

Self-checking stimulus/checker sequencer for single-clock regression tops. It generates a 64-bit LFSR stimulus word for the device under test and holds the DUT in reset for a fixed settle window. It then folds the DUT result into a 64-bit signature over a fixed cycle window and reports done/pass. The enclosing test top instantiates it beside the DUT and, on `done`, prints the finish banner and ends simulation.

---
 rtl/test_crc_seq_if.sv | 13 +
 rtl/test_crc_seq.sv | 51 +++++
 tb/tb_test_crc_seq.sv | 129 ++++++++++++
 3 files changed

// File: rtl/test_crc_seq_if.sv
// test_crc_seq_if: sequencer<->DUT bundle (result in; stim, dut_rst, cyc, running, done, pass, sum_out out)
interface test_crc_seq_if;
  logic [63:0] result;
  logic [63:0] stim;
  logic        dut_rst;
  logic [31:0] cyc;
  logic        running;
  logic        done;
  logic        pass;
  logic [63:0] sum_out;
  modport master(input result, output stim, dut_rst, cyc, running, done, pass, sum_out);
  modport slave(output result, input stim, dut_rst, cyc, running, done, pass, sum_out);
endinterface

// File: rtl/test_crc_seq.sv
// test_crc_seq: LFSR stimulus + DUT reset window + result signature sequencer (clk, rst, bus: result in, stim/dut_rst/cyc/running/done/pass/sum_out out)
module test_crc_seq #(
  parameter int unsigned NUM_CYC   = 99,
  parameter int unsigned RESET_CYC = 10,
  parameter logic [63:0] SEED      = 64'h5aef0c8d_d70a4497,
  parameter logic [63:0] EXP_SUM   = 64'h0
) (
  input logic            clk,
  input logic            rst,
  test_crc_seq_if.master bus
);
  typedef enum logic [1:0] {SETTLE, RUN, CHECK, DONE} state_t;
  state_t      r_state, w_state_nxt;
  logic [31:0] r_cyc;
  logic [63:0] r_stim, r_sum;
  logic        r_pass;
  function automatic logic [63:0] lfsr(input logic [63:0] v);
    return {v[62:0], v[63] ^ v[2] ^ v[0]};
  endfunction
  always_ff @(posedge clk)
    if (rst) r_state <= SETTLE;
    else     r_state <= w_state_nxt;
  // Leave each phase on the edge that makes cyc reach its boundary, so state always matches cyc.
  always_comb
    w_state_nxt = (r_state == SETTLE && r_cyc == RESET_CYC - 1) ? RUN   :
                  (r_state == RUN    && r_cyc == NUM_CYC - 1)   ? CHECK :
                  (r_state == CHECK)                            ? DONE  : r_state;
  always_ff @(posedge clk)
    if (rst) begin
      r_cyc  <= '0;
      r_stim <= SEED;
      r_sum  <= '0;
      r_pass <= 1'b0;
    end else begin
      if (r_state == SETTLE || r_state == RUN) begin
        r_cyc  <= r_cyc + 32'd1;
        r_stim <= lfsr(r_stim);
      end
      if (r_state == RUN)   r_sum  <= bus.result ^ lfsr(r_sum);
      if (r_state == CHECK) r_pass <= (r_sum == EXP_SUM);
    end
  always_comb begin
    bus.dut_rst = (r_state == SETTLE);
    bus.running = (r_state == RUN);
    bus.done    = (r_state == DONE);
    bus.pass    = r_pass;
    bus.cyc     = r_cyc;
    bus.stim    = r_stim;
    bus.sum_out = r_sum;
  end
endmodule

// File: tb/tb_test_crc_seq.sv
// tb_test_crc_seq: randomized checks of four test_crc_seq configurations against a cycle-count reference model
module tb_test_crc_seq;
  localparam int unsigned NC[4] = '{99, 99, 12, 12};
  localparam int unsigned RC[4] = '{10, 10, 10, 10};
  localparam logic [63:0] SD[4] = '{64'h5aef0c8d_d70a4497, 64'h1, 64'h5aef0c8d_d70a4497, 64'h5aef0c8d_d70a4497};
  localparam logic [63:0] EX[4] = '{64'h0, 64'h0, 64'h2, 64'h3};
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] res[4];
  logic [63:0] o_stim[4], o_sum[4];
  logic [31:0] o_cyc[4];
  logic        o_drst[4], o_run[4], o_done[4], o_pass[4];
  int unsigned m_k[4];
  logic [63:0] m_stim[4], m_sum[4];
  logic        m_pass[4];
  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] seq1[4];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : gi
    test_crc_seq_if bus();
    test_crc_seq #(.NUM_CYC(NC[g]), .RESET_CYC(RC[g]), .SEED(SD[g]), .EXP_SUM(EX[g])) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.master)
    );
    assign bus.result = res[g];
    assign o_stim[g]  = bus.stim;
    assign o_sum[g]   = bus.sum_out;
    assign o_cyc[g]   = bus.cyc;
    assign o_drst[g]  = bus.dut_rst;
    assign o_run[g]   = bus.running;
    assign o_done[g]  = bus.done;
    assign o_pass[g]  = bus.pass;
  end
  function automatic logic [63:0] lfsr(input logic [63:0] v);
    return {v[62:0], v[63] ^ v[2] ^ v[0]};
  endfunction
  // m_k counts edges since release, saturating at NUM_CYC+1 (= done).
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (rst) begin
        m_k[i]    <= 0;
        m_stim[i] <= SD[i];
        m_sum[i]  <= '0;
        m_pass[i] <= 1'b0;
      end else begin
        if (m_k[i] >= RC[i] && m_k[i] < NC[i]) m_sum[i] <= res[i] ^ lfsr(m_sum[i]);
        if (m_k[i] < NC[i]) m_stim[i] <= lfsr(m_stim[i]);
        if (m_k[i] == NC[i]) m_pass[i] <= (m_sum[i] == EX[i]);
        if (m_k[i] <= NC[i]) m_k[i] <= m_k[i] + 1;
      end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d.cyc", i), 64'(o_cyc[i]), 64'(m_k[i] > NC[i] ? NC[i] : m_k[i]));
      chk($sformatf("u%0d.stim", i), o_stim[i], m_stim[i]);
      chk($sformatf("u%0d.sum", i), o_sum[i], m_sum[i]);
      chk($sformatf("u%0d.dut_rst", i), 64'(o_drst[i]), 64'(m_k[i] < RC[i]));
      chk($sformatf("u%0d.running", i), 64'(o_run[i]), 64'(m_k[i] >= RC[i] && m_k[i] < NC[i]));
      chk($sformatf("u%0d.done", i), 64'(o_done[i]), 64'(m_k[i] > NC[i]));
      chk($sformatf("u%0d.pass", i), 64'(o_pass[i]), 64'(m_pass[i]));
    end
  endtask
  task automatic drive();
    res[0] = '0;
    res[1] = {$urandom, $urandom};
    res[2] = (m_k[2] < 13) ? 64'h1 : {$urandom, $urandom};
    res[3] = res[2];
  endtask
  initial begin
    seq1 = '{64'h1, 64'h3, 64'h7, 64'hE};
    for (int i = 0; i < 4; i++) res[i] = '0;
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;
    for (int t = 0; t < 50; t++) begin
      check_all();
      if (t < 4) begin
        chk("seed1_stim", o_stim[1], seq1[t]);
        chk("seed1_dut_rst", 64'(o_drst[1]), 64'h1);
      end
      if (t == 13) begin
        chk("n12_sum", o_sum[2], 64'h2);
        chk("n12_done", 64'(o_done[2]), 64'h1);
        chk("n12_pass", 64'(o_pass[2]), 64'h1);
        chk("n12_bad_sum", o_sum[3], 64'h2);
        chk("n12_bad_pass", 64'(o_pass[3]), 64'h0);
      end
      if (t > 13) chk("n12_frozen_cyc", 64'(o_cyc[2]), 64'd12);
      drive();
      @(negedge clk);
    end
    check_all();
    chk("mid_run_cyc", 64'(o_cyc[0]), 64'd50);
    rst = 1'b1;
    drive();
    @(negedge clk);
    rst = 1'b0;
    check_all();
    chk("rst_cyc", 64'(o_cyc[0]), 64'h0);
    chk("rst_stim", o_stim[0], 64'h5aef0c8d_d70a4497);
    chk("rst_sum", o_sum[0], 64'h0);
    chk("rst_dut_rst", 64'(o_drst[0]), 64'h1);
    chk("rst_done", 64'(o_done[0]), 64'h0);
    for (int t = 0; t < 125; t++) begin
      check_all();
      if (t == 99) chk("def_done_early", 64'(o_done[0]), 64'h0);
      if (t == 100) begin
        chk("def_done", 64'(o_done[0]), 64'h1);
        chk("def_pass", 64'(o_pass[0]), 64'h1);
        chk("def_sum", o_sum[0], 64'h0);
      end
      if (t == 10) chk("def_running_rise", 64'(o_run[0]), 64'h1);
      if (t == 99) chk("def_running_fall", 64'(o_run[0]), 64'h0);
      drive();
      @(negedge clk);
    end
    check_all();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
